audio_out_ctrl: RTL and testbench
=================================

Name: audio_out_ctrl

Overview:
- Output stage directly downstream of the music player; consumes its raw square-wave `audio` tone and drives the board speaker/buzzer pin.
- Synchronises the tone into `clk` (the player's tone comes from divided clocks) and measures its half-period.
- Applies PWM volume gating, with click-free start/stop aligned to tone edges.
- Detects silence (rests, music disabled) and reports playback status to game logic.

Parameters:
- PWM_BITS, 4: volume/PWM counter width.
- SILENCE_CYC, 1000000: clk cycles without a tone edge before the tone is declared absent (20 ms at 50 MHz); must be ≥2.
- FADE_SHIFT, 16: fade-in step interval is 2^FADE_SHIFT clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous assert, active-low.
- audio_in  in  1  raw tone from the music player; asynchronous to clk.
- enable  in  1  master sound enable from game logic.
- volume  in  PWM_BITS  requested volume; 0 = silent, all-ones = full.
- audio_out  out  1  gated tone to the speaker pin, registered.
- playing  out  1  high in states PLAY and DRAIN.
- half_period  out  16  last measured clk count between consecutive tone edges; saturating.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (ports clk, rst_n).
  - While rst_n=0: all outputs 0, state IDLE, all counters 0.
  - Reset asserted mid-operation forces this immediately.
- Synchroniser: 2-flop s1→s2; a_d = s2 delayed 1 cycle.
  - rise = s2 & ~a_d; fall = ~s2 & a_d; edge = rise | fall.
- Half-period counter hp_cnt (16 b):
  - On edge: half_period <= hp_cnt; hp_cnt <= 1.
  - Otherwise hp_cnt increments, saturating at 65535.
  - A measurement saturated at 65535 is latched as 65535.
- Silence counter:
  - Cleared on edge, otherwise increments, saturating.
  - silent = (count == SILENCE_CYC-1).
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps.
  - gate = 1 if eff_vol is all-ones; else gate = (pwm_cnt < eff_vol).
  - eff_vol = volume unless the fade feature is enabled.
- FSM (one-hot or encoded; registered state):
  - IDLE: enable=1 → ARM.
  - ARM: enable=0 → IDLE; rise → PLAY.
  - PLAY:
    - enable=0 & s2=0 → IDLE.
    - enable=0 & s2=1 → DRAIN.
    - silent → ARM.
    - Priority: enable=0 over silent.
  - DRAIN: fall or silent → IDLE.
    - enable re-asserted in DRAIN → PLAY, unless fall or silent occurs in the same cycle (then IDLE).
- audio_out <= (next_state ∈ {PLAY, DRAIN}) & s2 & gate.
  - Latency: audio_in rise to audio_out rise is 3 clk edges.
- Output only ever starts on a tone rise and ends on a tone fall or silence, so no truncated high phase at start or stop.
- playing <= (next_state ∈ {PLAY, DRAIN}), aligned with audio_out.
- volume change takes effect on the next clk; no re-sync needed (quasi-static from registers).

Optional Feature:
- Macro AUDIO_OUT_FADE_EN.
- Defined:
  - eff_vol is a register, cleared on every ARM→PLAY transition.
  - It then increments by 1 every 2^FADE_SHIFT cycles while in PLAY/DRAIN until it equals volume.
  - If volume < eff_vol, eff_vol <= volume on the next clk.
  - Cleared in IDLE/ARM.
- Undefined: eff_vol = volume combinationally; no fade registers are synthesised.

Test Plan:
- Reset: rst_n=0 mid-PLAY with audio_out=1 → audio_out, playing, half_period = 0 in the same cycle without a clk edge; state IDLE after release.
- Tone playback: enable=1, volume=15, audio_in square with 25000-clk half-period → audio_out copies audio_in delayed 3 clk, playing=1; half_period=25000 after the second edge.
- Volume gating: PWM_BITS=4, volume=8 → during tone-high, audio_out repeats 8 high/8 low per 16 clk; volume=0 → audio_out stays 0 while playing=1.
- Clean stop: enable dropped 100 clk into a 25000-clk high phase → audio_out stays gated high until the synchronised fall, then 0; playing=0 the same cycle; no later pulse.
- Silence: SILENCE_CYC=1000, audio_in held constant after playing → playing falls 1000 clk after the last synchronised edge (state ARM); the next rise restarts output 3 clk later.
- Fade (AUDIO_OUT_FADE_EN, FADE_SHIFT=4, volume=15) → eff_vol steps 0,1,…,15 every 16 clk after PLAY entry; dropping volume to 3 mid-fade → eff_vol=3 next clk.

Source files
------------

// File: rtl/audio_out_ctrl.sv
// rtl/audio_out_ctrl.sv - speaker output stage: tone sync, half-period measure, PWM volume, click-free gating; optional fade-in via AUDIO_OUT_FADE_EN
module audio_out_ctrl #(
  parameter int PWM_BITS    = 4,
  parameter int SILENCE_CYC = 1000000,
  parameter int FADE_SHIFT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                audio_in,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] volume,
  output logic                audio_out,
  output logic                playing,
  output logic [15:0]         half_period
);

  localparam int                SIL_W   = $clog2(SILENCE_CYC);
  localparam logic [SIL_W-1:0]  SIL_MAX = SIL_W'(SILENCE_CYC - 1);

  // Reject parameter values the counters below cannot represent.
  if (SILENCE_CYC < 2) begin : g_bad_silence
    $error("audio_out_ctrl: SILENCE_CYC must be at least 2");
  end
  if (FADE_SHIFT < 1) begin : g_bad_fade
    $error("audio_out_ctrl: FADE_SHIFT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ARM, PLAY, DRAIN} state_t;

  state_t              state, next_state;
  logic                s1, s2, a_d;
  logic                rise, fall, tone_edge;
  logic [15:0]         hp_cnt;
  logic [SIL_W-1:0]    sil_cnt;
  logic                silent;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] eff_vol;
  logic                gate;
  logic                next_active;

  assign rise      = s2 & ~a_d;
  assign fall      = ~s2 & a_d;
  assign tone_edge = rise | fall;
  assign silent    = (sil_cnt == SIL_MAX);

  // Two-flop synchroniser for the divided-clock tone, plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      a_d <= 1'b0;
    end else begin
      s1  <= audio_in;
      s2  <= s1;
      a_d <= s2;
    end
  end

  // Half-period measurement: count restarts at 1 on each edge, saturates so long gaps read as 65535.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt      <= '0;
      half_period <= '0;
    end else if (tone_edge) begin
      half_period <= hp_cnt;
      hp_cnt      <= 16'd1;
    end else if (hp_cnt != 16'hFFFF) begin
      hp_cnt      <= hp_cnt + 16'd1;
    end
  end

  // Silence timer: cycles since the last tone edge, held once the silence threshold is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sil_cnt <= '0;
    end else if (tone_edge) begin
      sil_cnt <= '0;
    end else if (!silent) begin
      sil_cnt <= sil_cnt + 1'b1;
    end
  end

  // Free-running PWM phase counter; wraps every 2^PWM_BITS cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

`ifdef AUDIO_OUT_FADE_EN
  logic [FADE_SHIFT-1:0] fade_cnt;

  // Fade-in ramp: restarts from zero outside PLAY/DRAIN, steps up once per fade interval, follows volume down at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eff_vol  <= '0;
      fade_cnt <= '0;
    end else if (state == PLAY || state == DRAIN) begin
      fade_cnt <= fade_cnt + 1'b1;
      if (volume < eff_vol) begin
        eff_vol <= volume;
      end else if ((&fade_cnt) && (eff_vol != volume)) begin
        eff_vol <= eff_vol + 1'b1;
      end
    end else begin
      eff_vol  <= '0;
      fade_cnt <= '0;
    end
  end
`else
  assign eff_vol = volume;
`endif

  assign gate = (&eff_vol) | (pwm_cnt < eff_vol);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start only on a tone rise, stop only on a tone fall or silence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (enable) next_state = ARM;
      end
      ARM: begin
        if (!enable)   next_state = IDLE;
        else if (rise) next_state = PLAY;
      end
      PLAY: begin
        if (!enable)     next_state = s2 ? DRAIN : IDLE;
        else if (silent) next_state = ARM;
      end
      DRAIN: begin
        if (fall || silent) next_state = IDLE;
        else if (enable)    next_state = PLAY;
      end
      default: next_state = IDLE;
    endcase
  end

  assign next_active = (next_state == PLAY) || (next_state == DRAIN);

  // Registered speaker drive and status, both keyed off the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_out <= 1'b0;
      playing   <= 1'b0;
    end else begin
      audio_out <= next_active & s2 & gate;
      playing   <= next_active;
    end
  end

endmodule

// File: tb/tb_audio_out_ctrl.sv
// tb/tb_audio_out_ctrl.sv - self-checking bench for audio_out_ctrl
module tb_audio_out_ctrl;

  localparam int PWM_BITS    = 4;
  localparam int SILENCE_CYC = 1000;
  localparam int FADE_SHIFT  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                audio_in;
  logic                enable;
  logic [PWM_BITS-1:0] volume;
  logic                audio_out;
  logic                playing;
  logic [15:0]         half_period;

  always #5 clk = ~clk;

  audio_out_ctrl #(
    .PWM_BITS   (PWM_BITS),
    .SILENCE_CYC(SILENCE_CYC),
    .FADE_SHIFT (FADE_SHIFT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .audio_in   (audio_in),
    .enable     (enable),
    .volume     (volume),
    .audio_out  (audio_out),
    .playing    (playing),
    .half_period(half_period)
  );

  typedef struct {
    logic aout;
    logic play;
    bit   chk;
  } exp_t;

  typedef struct {
    logic [PWM_BITS-1:0] vol;
    int                  highs;
  } pwm_vec_t;

  exp_t     sb[$];
  pwm_vec_t vecs[5];
  int       n_cmp = 0;
  int       n_err = 0;
  string    seq = "reset";

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", seq, name, act, exp, $time);
    end
  endtask

  // One clock: sample just after the edge, compare the entry pushed three drives ago, then drive and push.
  task automatic drive(input logic a, input logic en, input logic ea, input logic ep, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 3) begin
      e = sb.pop_front();
      if (e.chk) begin
        check("audio_out", int'(audio_out), int'(e.aout));
        check("playing", int'(playing), int'(e.play));
      end
    end
    audio_in = a;
    enable   = en;
    sb.push_back('{ea, ep, chk});
  endtask

  initial begin
    int highs;

    vecs[0] = '{4'd15, 16};
    vecs[1] = '{4'd8,  8};
    vecs[2] = '{4'd0,  0};
    vecs[3] = '{4'd1,  1};
    vecs[4] = '{4'd14, 14};

    rst_n    = 1'b0;
    audio_in = 1'b0;
    enable   = 1'b0;
    volume   = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    check("audio_out", int'(audio_out), 0);
    check("playing", int'(playing), 0);
    check("half_period", int'(half_period), 0);
    rst_n = 1'b1;

    seq = "hp25000";
    for (int i = 0; i < 25000; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("half_period", int'(half_period), 25000);

    seq = "playback";
    repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < 40; c++) begin
        drive(logic'(p % 2 == 0), 1'b1, logic'(p % 2 == 0), 1'b1, 1'b1);
      end
    end
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("half_period", int'(half_period), 40);

    seq = "pwm";
    repeat (5) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int v = 0; v < 5; v++) begin
      volume = vecs[v].vol;
      repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      highs = 0;
      repeat (16) begin
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        highs += int'(audio_out);
      end
      check($sformatf("highs_vol%0d", vecs[v].vol), highs, vecs[v].highs);
      check($sformatf("playing_vol%0d", vecs[v].vol), int'(playing), 1);
    end
    volume = 4'd15;
    repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    seq = "clean_stop";
    for (int i = 0; i < 300; i++) drive(1'b1, logic'(i < 100), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) drive(logic'((i / 50) % 2), 1'b0, 1'b0, 1'b0, 1'b1);

    seq = "silence";
    repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (40) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (40) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 1010; i++) drive(1'b1, 1'b1, logic'(i < 1000), logic'(i < 1000), 1'b1);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (40) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (40) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    seq = "async_reset";
    repeat (20) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("pre_audio_out", int'(audio_out), 1);
    check("pre_half_period", int'(half_period), 40);
    #2;
    rst_n = 1'b0;
    #1;
    check("audio_out", int'(audio_out), 0);
    check("playing", int'(playing), 0);
    check("half_period", int'(half_period), 0);
    sb.delete();
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    repeat (10) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (40) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
